// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO registers; fixed latency WIDTH+2 cycles from start to done.
// Operands are captured at start; start while busy is ignored and MTHI/MTLO writes are only taken when idle.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic               Clk,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   rs_val,
   input  logic [WIDTH-1:0]   rt_val,
   input  logic               hi_we,
   input  logic               lo_we,
   input  logic [WIDTH-1:0]   wr_data,
   output logic               busy,
   output logic               done,
   output logic               div_zero,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [WIDTH-1:0]   orig_a_q, orig_a_d;
   logic               is_div_q, is_div_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic               dz_op_q, dz_op_d;
   logic               div_zero_q, div_zero_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic               sa, sb;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     add_sum, rem_sh, diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opb_d      = opb_q;
      orig_a_d   = orig_a_q;
      is_div_d   = is_div_q;
      neg_res_d  = neg_res_q;
      neg_rem_d  = neg_rem_q;
      dz_op_d    = dz_op_q;
      div_zero_d = div_zero_q;
      hi_d       = hi_q;
      lo_d       = lo_q;

      // op[0] clear selects the signed variant of both MULT and DIV
      sa    = ~op[0] & rs_val[WIDTH-1];
      sb    = ~op[0] & rt_val[WIDTH-1];
      mag_a = sa ? -rs_val : rs_val;
      mag_b = sb ? -rt_val : rt_val;

      add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q & {WIDTH{acc_q[0]}}};
      rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      diff     = rem_sh - {1'b0, opb_q};
      prod_fix = neg_res_q ? -acc_q : acc_q;
      quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = CALC;
               cnt_d      = CNT_INIT;
               is_div_d   = op[1];
               neg_res_d  = sa ^ sb;
               neg_rem_d  = sa;
               orig_a_d   = rs_val;
               dz_op_d    = op[1] & (rt_val == '0);
               div_zero_d = op[1] & (rt_val == '0);
               opb_d      = op[1] ? mag_b : mag_a;
               acc_d      = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
            end else begin
               if (hi_we) hi_d = wr_data;
               if (lo_we) lo_d = wr_data;
            end
         end
         CALC: begin
            // divide: restoring step, quotient bit enters at the bottom; multiply: shift-add
            if (is_div_q) begin
               if (diff[WIDTH]) acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
               else             acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = {add_sum, acc_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) state_d = FIXUP;
         end
         FIXUP: begin
            state_d = DONE;
            if (dz_op_q) begin
               hi_d = orig_a_q;
               lo_d = '1;
            end else if (is_div_q) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         opb_q      <= '0;
         orig_a_q   <= '0;
         is_div_q   <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         dz_op_q    <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opb_q      <= opb_d;
         orig_a_q   <= orig_a_d;
         is_div_q   <= is_div_d;
         neg_res_q  <= neg_res_d;
         neg_rem_q  <= neg_rem_d;
         dz_op_q    <= dz_op_d;
         div_zero_q <= div_zero_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign div_zero = div_zero_q;
   assign hi       = hi_q;
   assign lo       = lo_q;
   assign product  = {hi_q, lo_q};

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: 32-bit instance for most scenarios, 8-bit instance for the narrow case.
module tb_mul_div_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, hi_we, lo_we;
   logic [1:0]  op;
   logic [31:0] rs_val, rt_val, wr_data;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;
   logic [63:0] product;

   logic        start8, hi_we8, lo_we8;
   logic [1:0]  op8;
   logic [7:0]  rs8, rt8, wr8;
   logic        busy8, done8, dz8;
   logic [7:0]  hi8, lo8;
   logic [15:0] product8;

   mul_div_unit #(.WIDTH(32)) dut (
      .Clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
      .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data), .busy(busy), .done(done),
      .div_zero(div_zero), .hi(hi), .lo(lo), .product(product)
   );

   mul_div_unit #(.WIDTH(8)) dut8 (
      .Clk(clk), .reset(reset), .start(start8), .op(op8), .rs_val(rs8), .rt_val(rt8),
      .hi_we(hi_we8), .lo_we(lo_we8), .wr_data(wr8), .busy(busy8), .done(done8),
      .div_zero(dz8), .hi(hi8), .lo(lo8), .product(product8)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   exp_t sb_q[$];
   int   nchk = 0;
   int   nerr = 0;

   function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [63:0] p;
      longint      pa, pb;
      int          ia, ib;
      e.dz = 1'b0;
      e.hi = '0;
      e.lo = '0;
      case (o)
         2'b00: begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
            p  = pa * pb;
            e.hi = p[63:32];
            e.lo = p[31:0];
         end
         2'b01: begin
            p = {32'b0, a} * {32'b0, b};
            e.hi = p[63:32];
            e.lo = p[31:0];
         end
         2'b10: begin
            ia = a;
            ib = b;
            if (b == 32'd0) begin
               e.dz = 1'b1; e.hi = a; e.lo = 32'hFFFF_FFFF;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               e.hi = 32'd0; e.lo = 32'h8000_0000;
            end else begin
               e.lo = ia / ib;
               e.hi = ia % ib;
            end
         end
         default: begin
            if (b == 32'd0) begin
               e.dz = 1'b1; e.hi = a; e.lo = 32'hFFFF_FFFF;
            end else begin
               e.lo = a / b;
               e.hi = a % b;
            end
         end
      endcase
      return e;
   endfunction

   // Start pulse in cycle 0; returns at the negedge of cycle 1 with operands scrambled.
   task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; op = o; rs_val = a; rt_val = b;
      @(negedge clk);
      start = 1'b0; op = 2'($urandom); rs_val = $urandom; rt_val = $urandom;
   endtask

   task automatic wait_done(input int from_cyc, output int done_cyc, output bit busy_ok);
      int cyc;
      cyc = from_cyc;
      done_cyc = -1;
      busy_ok = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (done === 1'b1) begin
            done_cyc = cyc;
            break;
         end
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      nchk++; if (busy !== 1'b0)     begin nerr++; $display("FAIL reset_busy: got %b expected 0", busy); end
      nchk++; if (done !== 1'b0)     begin nerr++; $display("FAIL reset_done: got %b expected 0", done); end
      nchk++; if (div_zero !== 1'b0) begin nerr++; $display("FAIL reset_div_zero: got %b expected 0", div_zero); end
      nchk++; if (product !== 64'd0) begin nerr++; $display("FAIL reset_product: got %h expected 0", product); end
   endtask

   task automatic test_multu_max();
      exp_t e;
      int   dc;
      bit   bok;
      sb_q.push_back('{hi: 32'hFFFF_FFFE, lo: 32'h0000_0001, dz: 1'b0});
      launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(1, dc, bok);
      e = sb_q.pop_front();
      nchk++; if (dc !== 34)  begin nerr++; $display("FAIL multu_done_cycle: got %0d expected 34", dc); end
      nchk++; if (bok !== 1'b1) begin nerr++; $display("FAIL multu_busy_window: got %b expected 1", bok); end
      nchk++; if (hi !== e.hi) begin nerr++; $display("FAIL multu_hi: got %h expected %h", hi, e.hi); end
      nchk++; if (lo !== e.lo) begin nerr++; $display("FAIL multu_lo: got %h expected %h", lo, e.lo); end
      nchk++; if (product !== {e.hi, e.lo}) begin nerr++; $display("FAIL multu_product: got %h expected %h", product, {e.hi, e.lo}); end
      @(negedge clk);
      nchk++; if ({busy, done} !== 2'b00) begin nerr++; $display("FAIL multu_after_done: got %b expected 00", {busy, done}); end
   endtask

   task automatic test_signed();
      logic [1:0]  ops[3] = '{2'b00, 2'b10, 2'b11};
      logic [31:0] as[3]  = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd7};
      logic [31:0] bs[3]  = '{32'd5, 32'd2, 32'd2};
      exp_t e;
      int   dc;
      bit   bok;
      for (int k = 0; k < 3; k++) begin
         sb_q.push_back(model(ops[k], as[k], bs[k]));
         launch(ops[k], as[k], bs[k]);
         wait_done(1, dc, bok);
         e = sb_q.pop_front();
         nchk++; if (dc !== 34)   begin nerr++; $display("FAIL signed%0d_cycle: got %0d expected 34", k, dc); end
         nchk++; if (hi !== e.hi) begin nerr++; $display("FAIL signed%0d_hi: got %h expected %h", k, hi, e.hi); end
         nchk++; if (lo !== e.lo) begin nerr++; $display("FAIL signed%0d_lo: got %h expected %h", k, lo, e.lo); end
      end
   endtask

   task automatic test_div_zero();
      logic [1:0]  ops[3] = '{2'b11, 2'b10, 2'b01};
      logic [31:0] as[3]  = '{32'd7, 32'hFFFF_FFFB, 32'd2};
      logic [31:0] bs[3]  = '{32'd0, 32'd0, 32'd3};
      exp_t e;
      int   dc;
      bit   bok;
      for (int k = 0; k < 3; k++) begin
         sb_q.push_back(model(ops[k], as[k], bs[k]));
         launch(ops[k], as[k], bs[k]);
         e = sb_q.pop_front();
         nchk++; if (div_zero !== e.dz) begin nerr++; $display("FAIL dz%0d_capture: got %b expected %b", k, div_zero, e.dz); end
         wait_done(1, dc, bok);
         nchk++; if (dc !== 34)   begin nerr++; $display("FAIL dz%0d_cycle: got %0d expected 34", k, dc); end
         nchk++; if (hi !== e.hi) begin nerr++; $display("FAIL dz%0d_hi: got %h expected %h", k, hi, e.hi); end
         nchk++; if (lo !== e.lo) begin nerr++; $display("FAIL dz%0d_lo: got %h expected %h", k, lo, e.lo); end
         nchk++; if (div_zero !== e.dz) begin nerr++; $display("FAIL dz%0d_flag: got %b expected %b", k, div_zero, e.dz); end
      end
   endtask

   task automatic test_overflow();
      exp_t e;
      int   dc;
      bit   bok;
      sb_q.push_back('{hi: 32'd0, lo: 32'h8000_0000, dz: 1'b0});
      launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(1, dc, bok);
      e = sb_q.pop_front();
      nchk++; if (hi !== e.hi) begin nerr++; $display("FAIL ovf_hi: got %h expected %h", hi, e.hi); end
      nchk++; if (lo !== e.lo) begin nerr++; $display("FAIL ovf_lo: got %h expected %h", lo, e.lo); end
      nchk++; if (div_zero !== e.dz) begin nerr++; $display("FAIL ovf_dz: got %b expected %b", div_zero, e.dz); end
   endtask

   task automatic test_start_busy_mt();
      exp_t e;
      int   dc;
      bit   bok;
      sb_q.push_back(model(2'b01, 32'd5, 32'd7));
      launch(2'b01, 32'd5, 32'd7);
      repeat (9) @(negedge clk);
      start = 1'b1; op = 2'b00; rs_val = 32'd9; rt_val = 32'd9;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      hi_we = 1'b1; wr_data = 32'hDEAD_BEEF;
      @(negedge clk);
      hi_we = 1'b0;
      wait_done(13, dc, bok);
      e = sb_q.pop_front();
      nchk++; if (dc !== 34)   begin nerr++; $display("FAIL busy_ign_cycle: got %0d expected 34", dc); end
      nchk++; if (hi !== e.hi) begin nerr++; $display("FAIL busy_ign_hi: got %h expected %h", hi, e.hi); end
      nchk++; if (lo !== e.lo) begin nerr++; $display("FAIL busy_ign_lo: got %h expected %h", lo, e.lo); end
      @(negedge clk);
      hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'hA5A5_A5A5;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
      nchk++; if (product !== 64'hA5A5_A5A5_A5A5_A5A5) begin nerr++; $display("FAIL mthi_mtlo: got %h expected a5a5a5a5a5a5a5a5", product); end
      // start and write together: the write must be dropped
      sb_q.push_back(model(2'b01, 32'd2, 32'd3));
      start = 1'b1; op = 2'b01; rs_val = 32'd2; rt_val = 32'd3; hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h1234_5678;
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      nchk++; if (hi !== 32'hA5A5_A5A5) begin nerr++; $display("FAIL start_wins_hi: got %h expected a5a5a5a5", hi); end
      wait_done(1, dc, bok);
      e = sb_q.pop_front();
      nchk++; if (lo !== e.lo) begin nerr++; $display("FAIL start_wins_lo: got %h expected %h", lo, e.lo); end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   dc;
      bit   bok;
      sb_q.push_back(model(2'b01, 32'h1234_5678, 32'h9ABC_DEF0));
      launch(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
      wait_done(1, dc, bok);
      e = sb_q.pop_front();
      nchk++; if (product !== {e.hi, e.lo}) begin nerr++; $display("FAIL b2b_first: got %h expected %h", product, {e.hi, e.lo}); end
      start = 1'b1; op = 2'b01; rs_val = 32'd4; rt_val = 32'd4;
      @(negedge clk);
      nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL b2b_done_start: got busy %b expected 0", busy); end
      sb_q.push_back(model(2'b01, 32'd6, 32'd7));
      rs_val = 32'd6; rt_val = 32'd7;
      @(negedge clk);
      start = 1'b0;
      wait_done(36, dc, bok);
      e = sb_q.pop_front();
      nchk++; if (dc !== 69)   begin nerr++; $display("FAIL b2b_cycle: got %0d expected 69", dc); end
      nchk++; if (lo !== e.lo) begin nerr++; $display("FAIL b2b_lo: got %h expected %h", lo, e.lo); end
   endtask

   task automatic test_reset_abort();
      exp_t e;
      int   dc;
      bit   bok;
      bit   saw_done;
      saw_done = 1'b0;
      launch(2'b11, 32'd100, 32'd3);
      for (int c = 2; c <= 15; c++) begin
         @(negedge clk);
         if (done === 1'b1) saw_done = 1'b1;
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      nchk++; if (busy !== 1'b0)     begin nerr++; $display("FAIL abort_busy: got %b expected 0", busy); end
      nchk++; if (product !== 64'd0) begin nerr++; $display("FAIL abort_hilo: got %h expected 0", product); end
      for (int c = 0; c < 25; c++) begin
         if (done === 1'b1) saw_done = 1'b1;
         @(negedge clk);
      end
      nchk++; if (saw_done !== 1'b0) begin nerr++; $display("FAIL abort_no_done: got %b expected 0", saw_done); end
      sb_q.push_back(model(2'b11, 32'd100, 32'd3));
      launch(2'b11, 32'd100, 32'd3);
      wait_done(1, dc, bok);
      e = sb_q.pop_front();
      nchk++; if (hi !== e.hi) begin nerr++; $display("FAIL abort_redo_hi: got %h expected %h", hi, e.hi); end
      nchk++; if (lo !== e.lo) begin nerr++; $display("FAIL abort_redo_lo: got %h expected %h", lo, e.lo); end
   endtask

   task automatic test_width8();
      int cyc;
      @(negedge clk);
      start8 = 1'b1; op8 = 2'b01; rs8 = 8'hFF; rt8 = 8'hFF;
      @(negedge clk);
      start8 = 1'b0; rs8 = 8'h00; rt8 = 8'h00;
      cyc = 1;
      while (done8 !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      nchk++; if (cyc !== 10) begin nerr++; $display("FAIL w8_cycle: got %0d expected 10", cyc); end
      nchk++; if (product8 !== 16'hFE01) begin nerr++; $display("FAIL w8_product: got %h expected fe01", product8); end
      nchk++; if ({busy8, dz8, hi8, lo8} !== {1'b1, 1'b0, 8'hFE, 8'h01}) begin
         nerr++; $display("FAIL w8_outputs: got %b %b %h %h expected 1 0 fe 01", busy8, dz8, hi8, lo8);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
      hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
      start8 = 1'b0; op8 = 2'b00; rs8 = '0; rt8 = '0; hi_we8 = 1'b0; lo_we8 = 1'b0; wr8 = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      test_reset();
      test_multu_max();
      test_signed();
      test_div_zero();
      test_overflow();
      test_start_busy_mt();
      test_back_to_back();
      test_reset_abort();
      test_width8();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
